// File: rtl/ibex_alu_iter.sv
// ibex_alu_iter: handshaked multi-cycle ALU with a parametrised datapath width.
// Single-cycle ops are computed combinationally and registered on accept;
// shifts are performed iteratively, SHIFT_STEP bits per cycle.
module ibex_alu_iter #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             is_equal_o,
    output logic             err_o,
    output logic             busy_o
);

    // Shift amounts need AW bits; the counter gets one extra bit so that a
    // step of WIDTH is still representable.
    localparam int AW = $clog2(WIDTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_EQ  = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        KIND_SLL,
        KIND_SRL,
        KIND_SRA
    } shift_kind_t;

    state_t          state;
    shift_kind_t     shift_kind;
    shift_kind_t     kind_next;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]   remaining;
    logic            carry_q;
    logic            equal_q;
    logic            err_q;

    logic            accept;
    logic [WIDTH:0]  sum_ext;
    logic [WIDTH:0]  diff_ext;
    logic            operands_equal;
    logic [WIDTH-1:0] alu_result;
    logic            alu_carry;
    logic            alu_err;
    logic            is_shift;
    logic [CW-1:0]   shift_amt;
    logic [CW-1:0]   step_amt;
    logic [WIDTH-1:0] shifted;

    assign req_ready_o = !rst_i && (state == IDLE || (state == DONE && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;

    assign sum_ext        = {1'b0, operand_a_i} + {1'b0, operand_b_i};
    assign diff_ext       = {1'b0, operand_a_i} + {1'b0, ~operand_b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign operands_equal = (operand_a_i == operand_b_i);
    assign shift_amt      = CW'(operand_b_i[AW-1:0]);

    // Single-cycle result, carry and error flag for the opcode being offered.
    // Shifts preload the working register with A, which is also the final
    // result for a zero shift amount.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_err    = 1'b0;
        is_shift   = 1'b0;
        kind_next  = KIND_SLL;
        case (op_i)
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_carry  = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_result = diff_ext[WIDTH-1:0];
                alu_carry  = diff_ext[WIDTH];
            end
            OP_OR:  alu_result = operand_a_i | operand_b_i;
            OP_AND: alu_result = operand_a_i & operand_b_i;
            OP_XOR: alu_result = operand_a_i ^ operand_b_i;
            OP_EQ:  alu_result = {{(WIDTH-1){1'b0}}, operands_equal};
            OP_SLL: begin
                alu_result = operand_a_i;
                is_shift   = 1'b1;
                kind_next  = KIND_SLL;
            end
            OP_SRL: begin
                alu_result = operand_a_i;
                is_shift   = 1'b1;
                kind_next  = KIND_SRL;
            end
            OP_SRA: begin
                alu_result = operand_a_i;
                is_shift   = 1'b1;
                kind_next  = KIND_SRA;
            end
            default: alu_err = 1'b1;
        endcase
    end

    // One iteration of the shifter: move by the smaller of the step size and
    // the bits still outstanding, filling according to the latched shift kind.
    always_comb begin
        step_amt = (remaining < STEP) ? remaining : STEP;
        case (shift_kind)
            KIND_SLL: shifted = work << step_amt;
            KIND_SRL: shifted = work >> step_amt;
            KIND_SRA: shifted = $unsigned($signed(work) >>> step_amt);
            default:  shifted = work;
        endcase
    end

    // Control FSM plus registered result/flags; an accept always wins because
    // it can only happen in IDLE or in DONE while the response is consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            shift_kind <= KIND_SLL;
            work       <= '0;
            remaining  <= '0;
            carry_q    <= 1'b0;
            equal_q    <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            work       <= alu_result;
            carry_q    <= alu_carry;
            equal_q    <= operands_equal;
            err_q      <= alu_err;
            shift_kind <= kind_next;
            remaining  <= is_shift ? shift_amt : '0;
            state      <= (is_shift && shift_amt != '0) ? SHIFT : DONE;
        end else begin
            case (state)
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - step_amt;
                    if (remaining == step_amt) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = (state == DONE);
    assign busy_o      = (state == SHIFT);
    assign result_o    = work;
    assign carry_o     = carry_q;
    assign is_equal_o  = equal_q;
    assign err_o       = err_q;

endmodule
